// File: rtl/ui_sprite_overlay_if.sv
// ui_sprite_overlay_if: scan-in, slot-write and atlas-out signals of the
// sprite overlay address generator.
//   master : drives scan position, pix_valid, frame_start and slot writes;
//            receives pixel_addr / is_object / out_valid.
//   slave  : the overlay block itself.
interface ui_sprite_overlay_if #(
  parameter int ADDR_W = 17
) ();
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              pix_valid;
  logic              frame_start;
  logic              wr_en;
  logic [3:0]        wr_slot;
  logic [2:0]        wr_field;
  logic [8:0]        wr_data;
  logic [ADDR_W-1:0] pixel_addr;
  logic              is_object;
  logic              out_valid;

  modport master (
    output h_cnt, v_cnt, pix_valid, frame_start,
    output wr_en, wr_slot, wr_field, wr_data,
    input  pixel_addr, is_object, out_valid
  );

  modport slave (
    input  h_cnt, v_cnt, pix_valid, frame_start,
    input  wr_en, wr_slot, wr_field, wr_data,
    output pixel_addr, is_object, out_valid
  );
endinterface

// File: rtl/ui_sprite_overlay.sv
// ui_sprite_overlay: 2-stage pipelined UI sprite address generator.
// SLOTS programmable rectangles (slot 0 = highest priority) are written into a
// shadow set and copied to the active set on frame_start, so a frame never
// renders a half-updated layout. Per scanned pixel the block returns the atlas
// address of the winning sprite and an object flag, 2 cycles later.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ui_sprite_overlay_if.slave (scan in, slot writes, atlas out)

// Per-slot rectangle hit test; one instance per slot.
module ui_sprite_slot_hit (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [8:0] sx,
  input  logic [8:0] sy,
  input  logic [8:0] w,
  input  logic [8:0] h,
  input  logic       en,
  input  logic       bl,
  input  logic       blink_off,
  output logic       hit,
  output logic [9:0] dx,
  output logic [9:0] dy
);
  // 10-bit ends: 511+511 still fits, so the window never wraps.
  logic [9:0] x_end, y_end;
  assign x_end = {1'b0, sx} + {1'b0, w};
  assign y_end = {1'b0, sy} + {1'b0, h};

  assign hit = en && !(bl && blink_off) &&
               (x >= {1'b0, sx}) && (x < x_end) &&
               (y >= {1'b0, sy}) && (y < y_end);

  // Only meaningful on a hit, where the offset is below w/h.
  assign dx = x - {1'b0, sx};
  assign dy = y - {1'b0, sy};
endmodule

module ui_sprite_overlay #(
  parameter int SLOTS       = 8,
  parameter int ATLAS_W     = 360,
  parameter int ATLAS_H     = 240,
  parameter int ADDR_W      = 17,
  parameter int SCALE_SHIFT = 1,
  parameter int BLINK_BIT   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ui_sprite_overlay_if.slave  bus
);
  localparam int STAGES = 2;
  localparam int AREA   = ATLAS_W * ATLAS_H;

  // ---------------------------------------------------------------- slots
  logic [SLOTS-1:0][8:0] sh_x, sh_y, sh_w, sh_h, sh_srcx, sh_srcy;
  logic [SLOTS-1:0]      sh_en, sh_bl;
  logic [SLOTS-1:0][8:0] act_x, act_y, act_w, act_h, act_srcx, act_srcy;
  logic [SLOTS-1:0]      act_en, act_bl;
  logic [5:0]            frame_cnt;

  // Commit reads the shadow before this cycle's write lands, so a write
  // coinciding with frame_start becomes active one frame later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_x <= '0; sh_y <= '0; sh_w <= '0; sh_h <= '0;
      sh_srcx <= '0; sh_srcy <= '0; sh_en <= '0; sh_bl <= '0;
      act_x <= '0; act_y <= '0; act_w <= '0; act_h <= '0;
      act_srcx <= '0; act_srcy <= '0; act_en <= '0; act_bl <= '0;
      frame_cnt <= '0;
    end else begin
      if (bus.frame_start) begin
        act_x <= sh_x; act_y <= sh_y; act_w <= sh_w; act_h <= sh_h;
        act_srcx <= sh_srcx; act_srcy <= sh_srcy;
        act_en <= sh_en; act_bl <= sh_bl;
        frame_cnt <= frame_cnt + 6'd1;
      end
      // Slot indices >= SLOTS match no entry and are dropped.
      for (int i = 0; i < SLOTS; i++) begin
        if (bus.wr_en && bus.wr_slot == 4'(i)) begin
          case (bus.wr_field)
            3'd0: sh_x[i]    <= bus.wr_data;
            3'd1: sh_y[i]    <= bus.wr_data;
            3'd2: sh_w[i]    <= bus.wr_data;
            3'd3: sh_h[i]    <= bus.wr_data;
            3'd4: sh_srcx[i] <= bus.wr_data;
            3'd5: sh_srcy[i] <= bus.wr_data;
            3'd6: begin
              sh_en[i] <= bus.wr_data[0];
              sh_bl[i] <= bus.wr_data[1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // -------------------------------------------------------------- stage 1
  logic [9:0]             x, y;
  logic                   blink_off;
  logic [SLOTS-1:0]       hit;
  logic [SLOTS-1:0][9:0]  dx, dy;

  assign x         = bus.h_cnt >> SCALE_SHIFT;
  assign y         = bus.v_cnt >> SCALE_SHIFT;
  assign blink_off = frame_cnt[BLINK_BIT];

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    ui_sprite_slot_hit u_hit (
      .x         (x),
      .y         (y),
      .sx        (act_x[g]),
      .sy        (act_y[g]),
      .w         (act_w[g]),
      .h         (act_h[g]),
      .en        (act_en[g]),
      .bl        (act_bl[g]),
      .blink_off (blink_off),
      .hit       (hit[g]),
      .dx        (dx[g]),
      .dy        (dy[g])
    );
  end

  // Walk from the lowest priority upward so the lowest hitting index wins.
  // The winner's atlas origin is captured here rather than looked up in
  // stage 2, so a commit between the stages cannot mix two layouts.
  logic       win_hit;
  logic [9:0] win_dx, win_dy;
  logic [8:0] win_srcx, win_srcy;

  always_comb begin
    win_hit  = 1'b0;
    win_dx   = '0;
    win_dy   = '0;
    win_srcx = '0;
    win_srcy = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_hit  = 1'b1;
        win_dx   = dx[i];
        win_dy   = dy[i];
        win_srcx = act_srcx[i];
        win_srcy = act_srcy[i];
      end
    end
  end

  logic              s1_hit;
  logic [9:0]        s1_dx, s1_dy;
  logic [8:0]        s1_srcx, s1_srcy;
  logic [STAGES:1]   vld_pipe;

  // -------------------------------------------------------------- stage 2
  logic [9:0]        col, row;
  logic [31:0]       lin;
  logic [ADDR_W-1:0] addr;
  logic              obj;
  logic [ADDR_W-1:0] addr_q;
  logic              obj_q;

  assign col  = {1'b0, s1_srcx} + s1_dx;
  assign row  = {1'b0, s1_srcy} + s1_dy;
  // Atlas reads past the last row wrap back to the top on purpose.
  assign lin  = 32'(row) * 32'(ATLAS_W) + 32'(col);
  assign addr = ADDR_W'(lin % 32'(AREA));
  assign obj  = s1_hit & vld_pipe[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_hit   <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_srcx  <= '0;
      s1_srcy  <= '0;
      vld_pipe <= '0;
      obj_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      s1_hit   <= win_hit;
      s1_dx    <= win_dx;
      s1_dy    <= win_dy;
      s1_srcx  <= win_srcx;
      s1_srcy  <= win_srcy;
      vld_pipe <= {vld_pipe[1], bus.pix_valid};
      obj_q    <= obj;
      addr_q   <= obj ? addr : '0;
    end
  end

  assign bus.pixel_addr = addr_q;
  assign bus.is_object  = obj_q;
  assign bus.out_valid  = vld_pipe[STAGES];
endmodule
